// File: rtl/hv_assoc_search.sv
// Sequential associative-memory search: fetches class hypervectors one at a time
// and reports the index and Hamming distance of the class nearest to the query.
module hv_assoc_search #(
  parameter int HVDimension    = 512,
  parameter int NumClass       = 32,
  parameter int ClassAddrWidth = $clog2(NumClass),
  parameter int DistWidth      = $clog2(HVDimension) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [HVDimension-1:0]    query_i,
  input  logic                      query_valid_i,
  output logic                      query_ready_o,
  input  logic [ClassAddrWidth:0]   num_class_i,
  output logic                      class_req_o,
  output logic [ClassAddrWidth-1:0] class_addr_o,
  input  logic [HVDimension-1:0]    class_rdata_i,
  input  logic                      class_rvalid_i,
  output logic [ClassAddrWidth-1:0] pred_o,
  output logic [DistWidth-1:0]      dist_o,
  output logic                      pred_valid_o,
  input  logic                      pred_ready_i,
  output logic                      busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam logic [ClassAddrWidth:0]   NumClassW = (ClassAddrWidth+1)'(NumClass);
  localparam logic [ClassAddrWidth:0]   CntOne    = (ClassAddrWidth+1)'(1);
  localparam logic [ClassAddrWidth-1:0] IdxOne    = ClassAddrWidth'(1);
  localparam logic [DistWidth-1:0]      DistMax   = '1;

  function automatic logic [DistWidth-1:0] popcount(input logic [HVDimension-1:0] v);
    logic [DistWidth-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < HVDimension; i++) begin
      cnt = cnt + DistWidth'(v[i]);
    end
    return cnt;
  endfunction

  state_e                    state_q, state_d;
  logic [HVDimension-1:0]    query_q, query_d;
  logic [ClassAddrWidth:0]   n_q, n_d;
  logic [ClassAddrWidth-1:0] idx_q, idx_d;
  logic [DistWidth-1:0]      min_q, min_d;
  logic [ClassAddrWidth-1:0] best_q, best_d;
  logic [ClassAddrWidth-1:0] pred_q, pred_d;
  logic [DistWidth-1:0]      dist_q, dist_d;

  logic [DistWidth-1:0]      dist_cur;
  logic [ClassAddrWidth:0]   n_clamp;
  logic                      closer;
  logic                      last;

  assign dist_cur = popcount(query_q ^ class_rdata_i);
  assign n_clamp  = (num_class_i > NumClassW) ? NumClassW : num_class_i;
  assign closer   = (dist_cur < min_q);
  assign last     = (({1'b0, idx_q} + CntOne) == n_q);

  always_comb begin
    state_d     = state_q;
    query_d     = query_q;
    n_d         = n_q;
    idx_d       = idx_q;
    min_d       = min_q;
    best_d      = best_q;
    pred_d      = pred_q;
    dist_d      = dist_q;
    class_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (query_valid_i) begin
          query_d = query_i;
          n_d     = n_clamp;
          idx_d   = '0;
          min_d   = DistMax;
          best_d  = '0;
          if (n_clamp == '0) begin
            pred_d  = '0;
            dist_d  = DistMax;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        class_req_o = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (class_rvalid_i) begin
          // Strict compare: on a tie the earlier (lower) index is kept.
          if (closer) begin
            min_d  = dist_cur;
            best_d = idx_q;
          end
          if (last) begin
            pred_d  = closer ? idx_q : best_q;
            dist_d  = closer ? dist_cur : min_q;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IdxOne;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        if (pred_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      query_q <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      min_q   <= '0;
      best_q  <= '0;
      pred_q  <= '0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      query_q <= query_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      min_q   <= min_d;
      best_q  <= best_d;
      pred_q  <= pred_d;
      dist_q  <= dist_d;
    end
  end

  assign query_ready_o = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign pred_valid_o  = (state_q == DONE);
  assign class_addr_o  = idx_q;
  assign pred_o        = pred_q;
  assign dist_o        = dist_q;

endmodule

// File: tb/tb_hv_assoc_search.sv
// Bench for hv_assoc_search: directed vector table, hand-written corner sequences
// and randomized searches against a nearest-class reference model.
module tb_hv_assoc_search;

  localparam int HVD = 512;
  localparam int NC  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [HVD-1:0] query_i = '0;
  logic           query_valid_i = 1'b0;
  logic           query_ready_o;
  logic [2:0]     num_class_i = '0;
  logic           class_req_o;
  logic [1:0]     class_addr_o;
  logic [HVD-1:0] class_rdata;
  logic           class_rvalid;
  logic [1:0]     pred_o;
  logic [9:0]     dist_o;
  logic           pred_valid_o;
  logic           pred_ready_i = 1'b0;
  logic           busy_o;

  always #5 clk = ~clk;

  hv_assoc_search #(.HVDimension(HVD), .NumClass(NC)) dut (
    .clk_i(clk), .rst_i(rst),
    .query_i(query_i), .query_valid_i(query_valid_i), .query_ready_o(query_ready_o),
    .num_class_i(num_class_i),
    .class_req_o(class_req_o), .class_addr_o(class_addr_o),
    .class_rdata_i(class_rdata), .class_rvalid_i(class_rvalid),
    .pred_o(pred_o), .dist_o(dist_o), .pred_valid_o(pred_valid_o),
    .pred_ready_i(pred_ready_i), .busy_o(busy_o)
  );

  // Class memory model: answers each request after L cycles (1, 3, or alternating).
  logic [3:0][HVD-1:0] mem;
  logic           mem_rvalid = 1'b0;
  logic [HVD-1:0] mem_rdata = '0;
  logic           stray = 1'b0;
  logic           stray_en = 1'b0;
  logic [HVD-1:0] stray_data = '0;
  int             lat_mode = 0;
  int             req_num = 0;
  int             mem_addr;
  int             mem_lat;
  logic [1:0]     req_log[$];

  assign class_rvalid = mem_rvalid | stray;
  assign class_rdata  = stray ? stray_data : mem_rdata;

  initial begin
    forever begin
      @(negedge clk);
      if (class_req_o && !rst) begin
        mem_addr = int'(class_addr_o);
        mem_lat  = (lat_mode == 2) ? 3 : ((lat_mode == 1 && (req_num % 2) == 1) ? 3 : 1);
        req_num++;
        repeat (mem_lat) @(posedge clk);
        #1 mem_rvalid = 1'b1; mem_rdata = mem[mem_addr];
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (stray_en && class_req_o) begin
        stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
      end
    end
  end

  always @(negedge clk) if (class_req_o) req_log.push_back(class_addr_o);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: nearest class by Hamming distance over the first min(n, NC) classes.
  function automatic void ref_search(input logic [HVD-1:0] q, input logic [3:0][HVD-1:0] c,
                                     input int n, output int p, output int d);
    int nn;
    int dd;
    nn = (n > NC) ? NC : n;
    p  = 0;
    d  = 1023;
    for (int i = 0; i < nn; i++) begin
      dd = $countones(q ^ c[i]);
      if (dd < d) begin
        d = dd;
        p = i;
      end
    end
  endfunction

  function automatic logic [HVD-1:0] rand_hv();
    logic [HVD-1:0] v;
    for (int i = 0; i < HVD/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic wait_result(input string name, output int cyc);
    cyc = 1;
    while (!pred_valid_o && cyc < 300) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({name, "_timeout"}, pred_valid_o, 1);
  endtask

  // Called #1 after a rising edge while idle; the next edge is the handshake (edge 0).
  task automatic run_query(input string name, input logic [HVD-1:0] q, input logic [2:0] n,
                           output int cyc);
    req_log.delete();
    req_num = 0;
    query_i = q;
    num_class_i = n;
    query_valid_i = 1'b1;
    @(posedge clk);
    #1 query_valid_i = 1'b0;
    wait_result(name, cyc);
  endtask

  task automatic consume();
    pred_ready_i = 1'b1;
    @(posedge clk);
    #1 pred_ready_i = 1'b0;
  endtask

  task automatic check_reqs(input string name, input int exp_n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < req_log.size(); i++) if (int'(req_log[i]) != i) ok = 1'b0;
    check({name, "_req_count"}, req_log.size(), exp_n);
    check({name, "_req_order"}, ok, 1);
  endtask

  typedef struct {
    string               name;
    logic [HVD-1:0]      query;
    logic [3:0][HVD-1:0] cls;
    logic [2:0]          n;
    logic [1:0]          exp_pred;
    logic [9:0]          exp_dist;
    int                  exp_cyc;
    int                  exp_reqs;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int cyc;
    int rp;
    int rd;
    int nn;
    logic found;
    logic flag_a;
    logic flag_b;
    logic [HVD-1:0] qa;
    logic [HVD-1:0] pat;
    logic [3:0][HVD-1:0] rc;

    pat = {128{4'hA}};
    vecs[0].name = "exact";
    vecs[0].query = pat;
    vecs[0].cls[0] = '0;  vecs[0].cls[1] = pat;
    vecs[0].cls[2] = '1;  vecs[0].cls[3] = ~pat;
    vecs[0].n = 3'd4; vecs[0].exp_pred = 2'd1; vecs[0].exp_dist = 10'd0;
    vecs[0].exp_cyc = 9; vecs[0].exp_reqs = 4;

    vecs[1].name = "tie";
    vecs[1].query = '0;
    vecs[1].cls[0] = 512'h1F;     vecs[1].cls[1] = 512'h1FF;
    vecs[1].cls[2] = 512'h1F000;  vecs[1].cls[3] = '1;
    vecs[1].n = 3'd4; vecs[1].exp_pred = 2'd0; vecs[1].exp_dist = 10'd5;
    vecs[1].exp_cyc = 9; vecs[1].exp_reqs = 4;

    vecs[2].name = "empty";
    vecs[2].query = pat;
    vecs[2].cls = vecs[0].cls;
    vecs[2].n = 3'd0; vecs[2].exp_pred = 2'd0; vecs[2].exp_dist = 10'd1023;
    vecs[2].exp_cyc = 1; vecs[2].exp_reqs = 0;

    mem = vecs[0].cls;
    #2 rst = 1'b1;
    #1;
    check("rst_query_ready", query_ready_o, 1);
    check("rst_class_req", class_req_o, 0);
    check("rst_class_addr", class_addr_o, 0);
    check("rst_pred", pred_o, 0);
    check("rst_dist", dist_o, 0);
    check("rst_pred_valid", pred_valid_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vector table.
    for (int v = 0; v < 3; v++) begin
      mem = vecs[v].cls;
      lat_mode = 0;
      run_query(vecs[v].name, vecs[v].query, vecs[v].n, cyc);
      check({vecs[v].name, "_cycle"}, cyc, vecs[v].exp_cyc);
      check({vecs[v].name, "_pred"}, pred_o, vecs[v].exp_pred);
      check({vecs[v].name, "_dist"}, dist_o, vecs[v].exp_dist);
      check_reqs(vecs[v].name, vecs[v].exp_reqs);
      consume();
      check({vecs[v].name, "_valid_drop"}, pred_valid_o, 0);
      check({vecs[v].name, "_pred_kept"}, pred_o, vecs[v].exp_pred);
      check({vecs[v].name, "_dist_kept"}, dist_o, vecs[v].exp_dist);
      check({vecs[v].name, "_ready_back"}, query_ready_o, 1);
    end

    // Clamp to NumClass plus result backpressure with a second query waiting.
    mem = vecs[0].cls;
    lat_mode = 0;
    run_query("clamp", pat, 3'd7, cyc);
    check("clamp_cycle", cyc, 9);
    check("clamp_pred", pred_o, 1);
    check("clamp_dist", dist_o, 0);
    check_reqs("clamp", 4);
    query_i = ~pat;
    num_class_i = 3'd4;
    query_valid_i = 1'b1;
    flag_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (pred_o != 2'd1 || dist_o != 10'd0 || !pred_valid_o || query_ready_o || class_req_o)
        flag_a = 1'b0;
      @(posedge clk);
      #1;
    end
    check("bp_stable", flag_a, 1);
    consume();
    check("bp_valid_drop", pred_valid_o, 0);
    check("bp_ready_after", query_ready_o, 1);
    check("bp_no_req_yet", class_req_o, 0);
    check("bp_pred_kept", pred_o, 1);
    req_log.delete();
    req_num = 0;
    @(posedge clk);
    #1 query_valid_i = 1'b0;
    check("bp_accept_busy", busy_o, 1);
    check("bp_accept_req", class_req_o, 1);
    wait_result("bp_second", cyc);
    check("bp_second_pred", pred_o, 3);
    check("bp_second_dist", dist_o, 0);
    consume();

    // Alternating latency 1/3 with a stray rvalid during every REQ cycle.
    lat_mode = 1;
    stray_data = pat;
    stray_en = 1'b1;
    run_query("varlat", pat, 3'd4, cyc);
    stray_en = 1'b0;
    check("varlat_cycle", cyc, 13);
    check("varlat_pred", pred_o, 1);
    check("varlat_dist", dist_o, 0);
    check_reqs("varlat", 4);
    consume();

    // Reset while waiting on class 2; its data arrives after reset is released.
    lat_mode = 2;
    req_num = 0;
    query_i = pat;
    num_class_i = 3'd4;
    query_valid_i = 1'b1;
    @(posedge clk);
    #1 query_valid_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (class_req_o && class_addr_o == 2'd2) found = 1'b1;
    end
    check("rst_mid_reach", found, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_ready", query_ready_o, 1);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_addr", class_addr_o, 0);
    check("rst_mid_pred", pred_o, 0);
    check("rst_mid_dist", dist_o, 0);
    check("rst_mid_valid", pred_valid_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    flag_a = 1'b0;
    flag_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (pred_valid_o || class_req_o) flag_a = 1'b1;
      if (!query_ready_o) flag_b = 1'b0;
      @(posedge clk);
      #1;
    end
    check("rst_mid_no_activity", flag_a, 0);
    check("rst_mid_idle", flag_b, 1);
    lat_mode = 0;
    run_query("after_rst", pat, 3'd4, cyc);
    check("after_rst_cycle", cyc, 9);
    check("after_rst_pred", pred_o, 1);
    check("after_rst_dist", dist_o, 0);
    consume();

    // Randomized searches against the reference model.
    for (int t = 0; t < 12; t++) begin
      qa = rand_hv();
      for (int c = 0; c < NC; c++) begin
        case ($urandom_range(0, 2))
          0: rc[c] = rand_hv();
          1: begin
            rc[c] = qa;
            for (int b = 0; b < int'($urandom_range(0, 40)); b++) rc[c][$urandom_range(0, HVD-1)] ^= 1'b1;
          end
          default: rc[c] = (c > 0) ? rc[c-1] : qa ^ rand_hv();
        endcase
      end
      mem = rc;
      nn = int'($urandom_range(0, 7));
      lat_mode = int'($urandom_range(0, 1));
      ref_search(qa, rc, nn, rp, rd);
      run_query("rand", qa, 3'(nn), cyc);
      check("rand_pred", pred_o, rp);
      check("rand_dist", dist_o, rd);
      check_reqs("rand", (nn > NC) ? NC : nn);
      if (lat_mode == 0) check("rand_cycle", cyc, 2 * ((nn > NC) ? NC : nn) + 1);
      consume();
      check("rand_valid_drop", pred_valid_o, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/hv_assoc_search.md
Name: hv_assoc_search

Overview:
- Sequential associative-memory search. It is the decode end of the encoder datapath.
- Accepts one encoded query hypervector and fetches up to NumClass stored class hypervectors, one at a time, from an external class memory.
- For each class it computes the Hamming distance popcount(query XOR class). It returns the index of the nearest class and that distance over a valid/ready output.

Parameters:
HVDimension, 512, bit width of query and class hypervectors
NumClass, 32, maximum number of stored classes
ClassAddrWidth, $clog2(NumClass), class memory address / predicted index width
DistWidth, $clog2(HVDimension)+1, Hamming distance width (holds 0..HVDimension)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
query_i  input  HVDimension  query hypervector
query_valid_i  input  1  query offered
query_ready_o  output  1  block can accept a query
num_class_i  input  ClassAddrWidth+1  number of classes to search; sampled on query handshake
class_req_o  output  1  one-cycle read request to class memory
class_addr_o  output  ClassAddrWidth  class index being read
class_rdata_i  input  HVDimension  class hypervector, valid when class_rvalid_i=1
class_rvalid_i  input  1  read data valid
pred_o  output  ClassAddrWidth  index of nearest class
dist_o  output  DistWidth  Hamming distance of nearest class
pred_valid_o  output  1  result valid
pred_ready_i  input  1  result consumer ready
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_i=1):
  - State goes to IDLE; all registers clear.
  - Output values: query_ready_o=1, class_req_o=0, class_addr_o=0, pred_o=0, dist_o=0, pred_valid_o=0, busy_o=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - query_ready_o=1.
  - On query_valid_i & query_ready_o, latch query_i into a query register.
  - Latch N = min(num_class_i, NumClass).
  - Clear the index counter to 0, set min_dist to all-ones, clear best_idx to 0.
  - If N==0, go to DONE; else go to REQ.
- REQ:
  - class_req_o=1 for exactly one cycle, with class_addr_o = index counter.
  - Then go to WAIT.
- WAIT:
  - class_req_o=0; class_addr_o holds its value.
  - On class_rvalid_i, compute d = popcount(query_reg ^ class_rdata_i) combinationally.
  - If d < min_dist (strict), set min_dist=d and best_idx=index counter. Ties therefore keep the lowest index.
  - If index counter == N-1, go to DONE; else increment the index counter and go to REQ.
- DONE:
  - pred_valid_o=1, pred_o=best_idx, dist_o=min_dist. All three stay stable until pred_ready_i=1.
  - On the handshake, go to IDLE. pred_valid_o deasserts the next cycle; pred_o and dist_o keep their last values.
  - A query can be accepted no earlier than the cycle after the result handshake.
- N==0 result: pred_o=0, dist_o=all-ones.
- class_rvalid_i outside WAIT is ignored. Only one read is outstanding at a time.
- query_ready_o=0 in REQ, WAIT and DONE.
- Latency:
  - Let the memory return rvalid L>=1 cycles after class_req_o (L may vary per request).
  - With handshake at edge 0 and fixed L, pred_valid_o first rises in cycle N*(L+1)+1.
  - For N==0, pred_valid_o rises in cycle 1.
- Reset mid-search: the state is aborted immediately. Late rvalid after reset deassertion is ignored, since the state is IDLE.
- Popcount is a full-width adder tree. No pipelining is inside the WAIT cycle; the whole distance is computed in that single cycle.

Test Plan:
Common setup for all scenarios: HVDimension=512, NumClass=4, memory model with L=1.
1. Exact match. Query = 512'hAAAA...A. Classes: 0=all-zeros, 1=query, 2=all-ones, 3=~query.
   -> class_req_o pulses at addr 0,1,2,3.
   -> pred_valid_o rises in cycle 9 with pred_o=1, dist_o=0.
2. Tie. Query = 0. Classes: 0=5 ones, 1=9 ones, 2=5 ones, 3=all-ones.
   -> pred_o=0, dist_o=5.
3. Empty search. num_class_i=0.
   -> No class_req_o.
   -> pred_valid_o in cycle 1 with pred_o=0, dist_o=1023.
4. Clamp and backpressure. num_class_i=7 with pred_ready_i held low 5 cycles after pred_valid_o.
   -> Only addr 0..3 requested.
   -> pred_o and dist_o stable throughout, query_ready_o=0, a second query_valid_i is not accepted.
   -> After pred_ready_i=1, the next query is accepted one cycle later.
5. Variable latency. L alternates 1 and 3, with a stray rvalid injected in REQ.
   -> Stray pulse is ignored; result is identical to scenario 1.
6. Reset mid-op. rst_i pulsed while in WAIT for addr 2, and rvalid arrives after release.
   -> All outputs return to reset values, query_ready_o=1, no pred_valid_o.
   -> The next query completes normally.
